// File: rtl/gbf_fill_controller.sv
// Stream loader for one gbf double buffer: writes fixed-size tiles alternately
// into buffer 1 and buffer 2 and publishes their ready/data_avail status.
module gbf_fill_controller #(
    parameter int unsigned DATA_BITWIDTH     = 512,
    parameter int unsigned ADDR_BITWIDTH     = 5,
    parameter int unsigned DEPTH             = 32,
    parameter int unsigned TILE_WORDS        = 32,
    parameter int unsigned NUM_TILES         = 8,
    parameter int unsigned TILE_CNT_BITWIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [DATA_BITWIDTH-1:0] in_data,
    output logic                     in_ready,
    input  logic                     gbf1_need_data,
    input  logic                     gbf2_need_data,
    output logic                     en1a,
    output logic                     we1a,
    output logic [ADDR_BITWIDTH-1:0] addr1a,
    output logic [DATA_BITWIDTH-1:0] w_data1a,
    output logic                     en2a,
    output logic                     we2a,
    output logic [ADDR_BITWIDTH-1:0] addr2a,
    output logic [DATA_BITWIDTH-1:0] w_data2a,
    output logic                     buf1_ready,
    output logic                     buf2_ready,
    output logic                     data_avail,
    output logic                     all_loaded
);

    // Last word address of a tile, clamped so the write address never leaves the buffer.
    localparam int unsigned LAST_ADDR = ((TILE_WORDS < DEPTH) ? TILE_WORDS : DEPTH) - 1;

    typedef enum logic [2:0] {
        IDLE,
        FILL1,
        FILL2,
        COMMIT,
        DONE
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [ADDR_BITWIDTH-1:0]   word_cnt;
    logic [TILE_CNT_BITWIDTH-1:0] tile_cnt;
    logic                       target;
    logic                       accept;
    logic                       last_word;
    logic                       commit;

    assign last_word  = (word_cnt == ADDR_BITWIDTH'(LAST_ADDR));
    assign accept     = in_valid & in_ready;
    assign commit     = (state == COMMIT);
    assign data_avail = buf1_ready | buf2_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        all_loaded = 1'b0;
        case (state)
            IDLE: begin
                if (tile_cnt == TILE_CNT_BITWIDTH'(NUM_TILES)) begin
                    state_nxt = DONE;
                end else if (!target && !buf1_ready) begin
                    state_nxt = FILL1;
                end else if (target && !buf2_ready) begin
                    state_nxt = FILL2;
                end
            end
            FILL1, FILL2: begin
                in_ready = 1'b1;
                if (in_valid && last_word) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                state_nxt = IDLE;
            end
            DONE: begin
                all_loaded = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_cnt <= '0;
            tile_cnt <= '0;
            target   <= 1'b0;
        end else if (commit) begin
            word_cnt <= '0;
            tile_cnt <= tile_cnt + 1'b1;
            target   <= ~target;
        end else if (accept && !last_word) begin
            word_cnt <= word_cnt + 1'b1;
        end
    end

    // Write strobes are registered: one cycle after acceptance, held for one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en1a     <= 1'b0;
            we1a     <= 1'b0;
            addr1a   <= '0;
            w_data1a <= '0;
            en2a     <= 1'b0;
            we2a     <= 1'b0;
            addr2a   <= '0;
            w_data2a <= '0;
        end else begin
            en1a <= accept && (state == FILL1);
            we1a <= accept && (state == FILL1);
            en2a <= accept && (state == FILL2);
            we2a <= accept && (state == FILL2);
            if (accept && (state == FILL1)) begin
                addr1a   <= word_cnt;
                w_data1a <= in_data;
            end
            if (accept && (state == FILL2)) begin
                addr2a   <= word_cnt;
                w_data2a <= in_data;
            end
        end
    end

    // A commit to a buffer takes priority over a simultaneous drain request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf1_ready <= 1'b0;
            buf2_ready <= 1'b0;
        end else begin
            if (commit && !target) begin
                buf1_ready <= 1'b1;
            end else if (gbf1_need_data) begin
                buf1_ready <= 1'b0;
            end
            if (commit && target) begin
                buf2_ready <= 1'b1;
            end else if (gbf2_need_data) begin
                buf2_ready <= 1'b0;
            end
        end
    end

endmodule
